// File: rtl/adder_meas_pkg.sv
// Shared types and default widths for the ripple-adder measurement sequencer.
package adder_meas_pkg;

  localparam int unsigned DEF_WIDTH         = 32;
  localparam int unsigned DEF_CNT_W         = 32;
  localparam int unsigned DEF_WIN_W         = 16;
  localparam int unsigned DEF_RUNS_W        = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } meas_state_t;

endpackage

// File: rtl/meas_window_timer.sv
// Loadable down-counter; terminal count flags the last cycle of a RUN or SETTLE phase.
module meas_window_timer #(
  parameter int unsigned WIN_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             load,
  input  logic [WIN_W-1:0] load_value,
  output logic             tc_c
);

  logic [WIN_W-1:0] count_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIN_W'(1);
    end
  end

  assign tc_c = (count_q == '0);

endmodule

// File: rtl/adder_measure_sequencer.sv
// Drives operands into the instrumented adder, gates its ring-oscillator counter for N
// windows and accumulates the captured counts.
module adder_measure_sequencer
  import adder_meas_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned CNT_W         = DEF_CNT_W,
  parameter int unsigned WIN_W         = DEF_WIN_W,
  parameter int unsigned RUNS_W        = DEF_RUNS_W,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    start,
  input  logic                    abort,
  input  logic [WIDTH-1:0]        cfg_a,
  input  logic [WIDTH-1:0]        cfg_b,
  input  logic [WIN_W-1:0]        cfg_window,
  input  logic [RUNS_W-1:0]       cfg_runs,
  input  logic [CNT_W-1:0]        ring_count,
  output logic [WIDTH-1:0]        adder_a,
  output logic [WIDTH-1:0]        adder_b,
  output logic                    ring_en,
  output logic                    count_clr,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W+RUNS_W-1:0] acc_sum,
  output logic [CNT_W-1:0]        run_max,
  output logic                    error
);

  localparam int unsigned ACC_W = CNT_W + RUNS_W;

  meas_state_t       state_q, state_d;
  logic [WIN_W-1:0]  win_q, win_d;
  logic [RUNS_W-1:0] runs_q, runs_d;
  logic [WIDTH-1:0]  adder_a_d, adder_b_d;
  logic              ring_en_d, count_clr_d, busy_d, done_d, error_d;
  logic [ACC_W-1:0]  acc_sum_d;
  logic [CNT_W-1:0]  run_max_d;
  logic              timer_load;
  logic [WIN_W-1:0]  timer_value;
  logic              timer_tc_c;

  meas_window_timer #(.WIN_W(WIN_W)) u_timer (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .load       (timer_load),
    .load_value (timer_value),
    .tc_c       (timer_tc_c)
  );

  // State and every output register; outputs are computed for the state being entered.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      win_q     <= '0;
      runs_q    <= '0;
      adder_a   <= '0;
      adder_b   <= '0;
      ring_en   <= 1'b0;
      count_clr <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      acc_sum   <= '0;
      run_max   <= '0;
      error     <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      runs_q    <= runs_d;
      adder_a   <= adder_a_d;
      adder_b   <= adder_b_d;
      ring_en   <= ring_en_d;
      count_clr <= count_clr_d;
      busy      <= busy_d;
      done      <= done_d;
      acc_sum   <= acc_sum_d;
      run_max   <= run_max_d;
      error     <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    runs_d      = runs_q;
    adder_a_d   = adder_a;
    adder_b_d   = adder_b;
    ring_en_d   = 1'b0;
    count_clr_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    acc_sum_d   = acc_sum;
    run_max_d   = run_max;
    error_d     = error;
    timer_load  = 1'b0;
    timer_value = '0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          win_d  = cfg_window;
          runs_d = cfg_runs;
          if (cfg_window == '0 || cfg_runs == '0) begin
            state_d   = ST_DONE;
            done_d    = 1'b1;
            error_d   = 1'b1;
            acc_sum_d = '0;
            run_max_d = '0;
          end else begin
            state_d   = ST_LOAD;
            busy_d    = 1'b1;
            adder_a_d = cfg_a;
            adder_b_d = cfg_b;
            acc_sum_d = '0;
            run_max_d = '0;
            error_d   = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        state_d     = ST_CLEAR;
        busy_d      = 1'b1;
        count_clr_d = 1'b1;
      end
      ST_CLEAR: begin
        // Timer reaches zero on the last RUN cycle.
        state_d     = ST_RUN;
        busy_d      = 1'b1;
        ring_en_d   = 1'b1;
        timer_load  = 1'b1;
        timer_value = win_q - WIN_W'(1);
      end
      ST_RUN: begin
        busy_d = 1'b1;
        if (timer_tc_c) begin
          state_d     = ST_SETTLE;
          timer_load  = 1'b1;
          timer_value = WIN_W'(SETTLE_CYCLES - 1);
        end else begin
          ring_en_d = 1'b1;
        end
      end
      ST_SETTLE: begin
        busy_d = 1'b1;
        if (timer_tc_c) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        acc_sum_d = acc_sum + ACC_W'(ring_count);
        if (ring_count > run_max) begin
          run_max_d = ring_count;
        end
        if (ring_count == '0) begin
          error_d = 1'b1;
        end
        runs_d = runs_q - RUNS_W'(1);
        if (runs_q == RUNS_W'(1)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d     = ST_CLEAR;
          busy_d      = 1'b1;
          count_clr_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards the in-flight capture but keeps earlier partial results.
    if (abort && state_q != ST_IDLE) begin
      state_d     = ST_IDLE;
      ring_en_d   = 1'b0;
      count_clr_d = 1'b0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      error_d     = 1'b1;
      acc_sum_d   = acc_sum;
      run_max_d   = run_max;
      timer_load  = 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_measure_sequencer.sv
// Directed bench for adder_measure_sequencer: cycle-accurate phase timing, accumulation,
// config errors, abort, ignored start and mid-run reset.
module tb_adder_measure_sequencer;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        start;
  logic        abort;
  logic [31:0] cfg_a;
  logic [31:0] cfg_b;
  logic [15:0] cfg_window;
  logic [7:0]  cfg_runs;
  logic [31:0] ring_count;
  logic [31:0] adder_a;
  logic [31:0] adder_b;
  logic        ring_en;
  logic        count_clr;
  logic        busy;
  logic        done;
  logic [39:0] acc_sum;
  logic [31:0] run_max;
  logic        error;

  int checks = 0;
  int errors = 0;

  // observations gathered by measure()
  int en_first, en_last, en_cnt, clr_cnt, done_cnt, done_cyc;
  logic        s_ring_en, s_busy, s_error, s_done, s_clr;
  logic [39:0] s_acc;
  logic [31:0] s_max, s_adder_a;
  int          counts [3];

  always #5 wb_clk_i = ~wb_clk_i;

  adder_measure_sequencer dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start      (start),
    .abort      (abort),
    .cfg_a      (cfg_a),
    .cfg_b      (cfg_b),
    .cfg_window (cfg_window),
    .cfg_runs   (cfg_runs),
    .ring_count (ring_count),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .ring_en    (ring_en),
    .count_clr  (count_clr),
    .busy       (busy),
    .done       (done),
    .acc_sum    (acc_sum),
    .run_max    (run_max),
    .error      (error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // start is high in cycle 0; outputs of cycle k are sampled 1 time unit after its edge.
  task automatic measure(input logic [15:0] win, input logic [7:0] runs, input int abort_at,
                         input int start_at, input int rst_at, input int snap_at, input int ncyc);
    @(posedge wb_clk_i); #1;
    cfg_window = win;
    cfg_runs   = runs;
    start      = 1'b1;
    en_first = -1; en_last = -1; en_cnt = 0; clr_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge wb_clk_i); #1;
      start    = 1'b0;
      abort    = 1'b0;
      wb_rst_i = 1'b0;
      if (ring_en) begin
        if (en_first < 0) en_first = k;
        en_last = k;
        en_cnt++;
      end
      if (count_clr) begin
        clr_cnt++;
        ring_count = (clr_cnt <= 3) ? 32'(counts[clr_cnt-1]) : 32'd0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = k;
      end
      if (k == snap_at) begin
        s_ring_en = ring_en; s_busy = busy; s_error = error; s_done = done; s_clr = count_clr;
        s_acc = acc_sum; s_max = run_max; s_adder_a = adder_a;
      end
      if (k == abort_at) abort = 1'b1;
      if (k == rst_at) wb_rst_i = 1'b1;
      if (k == start_at) begin
        start      = 1'b1;
        cfg_window = 16'd20;
      end
    end
  endtask

  initial begin
    wb_rst_i = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_a = 32'hDEAD_BEEF; cfg_b = 32'h1234_5678;
    cfg_window = 16'd0; cfg_runs = 8'd0; ring_count = 32'd0;
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk("rst_state_busy", busy, 0);
    chk("rst_outputs", {ring_en, count_clr, done, error}, 0);
    chk("rst_acc", acc_sum, 0);
    chk("rst_adder_a", adder_a, 0);
    wb_rst_i = 1'b0;

    // 1: single run, W=4
    counts = '{50, 0, 0};
    measure(16'd4, 8'd1, -1, -1, -1, 9, 14);
    chk("t1_en_first", en_first, 3);
    chk("t1_en_last", en_last, 6);
    chk("t1_done_cyc", done_cyc, 10);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_capture", s_busy, 1);
    chk("t1_acc", acc_sum, 50);
    chk("t1_max", run_max, 50);
    chk("t1_err", error, 0);
    chk("t1_adder_a", adder_a, 32'hDEAD_BEEF);
    chk("t1_adder_b", adder_b, 32'h1234_5678);

    // 4: abort during RUN
    measure(16'd4, 8'd1, 5, -1, -1, 6, 14);
    chk("t4_ring_en", s_ring_en, 0);
    chk("t4_busy", s_busy, 0);
    chk("t4_err", s_error, 1);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_en_cnt", en_cnt, 3);

    // 2: three runs, W=10
    counts = '{100, 120, 110};
    cfg_a = 32'h0000_0F0F;
    measure(16'd10, 8'd3, -1, -1, -1, -1, 48);
    chk("t2_done_cyc", done_cyc, 44);
    chk("t2_acc", acc_sum, 330);
    chk("t2_max", run_max, 120);
    chk("t2_clr_cnt", clr_cnt, 3);
    chk("t2_en_cnt", en_cnt, 30);
    chk("t2_err", error, 0);
    chk("t2_adder_a", adder_a, 32'h0000_0F0F);

    // 3: zero window is a config error
    measure(16'd0, 8'd5, -1, -1, -1, 1, 5);
    chk("t3_done_cyc", done_cyc, 1);
    chk("t3_err", error, 1);
    chk("t3_en_cnt", en_cnt, 0);
    chk("t3_acc", acc_sum, 0);
    chk("t3_busy", s_busy, 0);

    // 5: zero count on the second run
    counts = '{40, 0, 60};
    measure(16'd3, 8'd3, -1, -1, -1, -1, 27);
    chk("t5_done_cyc", done_cyc, 23);
    chk("t5_done_cnt", done_cnt, 1);
    chk("t5_err", error, 1);
    chk("t5_acc", acc_sum, 100);
    chk("t5_max", run_max, 60);

    // 6a: start while busy is ignored
    counts = '{50, 0, 0};
    measure(16'd4, 8'd1, -1, 4, -1, -1, 30);
    chk("t6_busy_start_done", done_cyc, 10);
    chk("t6_busy_start_en", en_cnt, 4);
    chk("t6_busy_start_dcnt", done_cnt, 1);

    // 6b: reset during SETTLE
    measure(16'd4, 8'd1, -1, -1, 7, 8, 14);
    chk("t6_rst_ring_busy", {s_ring_en, s_busy, s_done, s_clr}, 0);
    chk("t6_rst_err", s_error, 0);
    chk("t6_rst_acc", s_acc, 0);
    chk("t6_rst_max", s_max, 0);
    chk("t6_rst_adder_a", s_adder_a, 0);
    chk("t6_rst_done_cnt", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
